// File: rtl/erasure_threshold_engine.sv
// Erasure cutoff engine: sigma^2 << SCALE_SHIFT divided by fade (one quotient bit per cycle), then one cutoff per table entry.
// Job latency CC_W+2+NUM_THR cycles (2+NUM_THR when fade=0). No backpressure. THRESH_PROG_EN enables run-time table writes.
module erasure_threshold_engine #(
    parameter int SIGMA_W     = 5,
    parameter int FADE_W      = 10,
    parameter int SCALE_SHIFT = 5,
    parameter int CC_W        = 15,
    parameter int THR_W       = 9,
    parameter int NUM_THR     = 4,
    parameter int IDX_W       = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_start,
    input  logic [SIGMA_W-1:0]               i_sigma_value,
    input  logic [FADE_W-1:0]                i_fade_value,
    input  logic                             i_thr_wr_en,
    input  logic [IDX_W-1:0]                 i_thr_wr_addr,
    input  logic signed [THR_W-1:0]          i_thr_wr_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_div_by_zero,
    output logic [2*SIGMA_W-1:0]             o_sigma_square,
    output logic [CC_W-1:0]                  o_channel_char,
    output logic                             o_cutoff_valid,
    output logic [IDX_W-1:0]                 o_cutoff_idx,
    output logic signed [CC_W+THR_W-1:0]     o_cutoff
);

    localparam int CNT_W = (CC_W > 1) ? $clog2(CC_W) : 1;
    localparam int CUT_W = CC_W + THR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_DIVIDE,
        S_MULT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SIGMA_W-1:0]      r_sigma;
    logic [FADE_W-1:0]       r_fade;
    logic [CC_W-1:0]         r_num;
    logic [FADE_W-1:0]       r_rem;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [2*SIGMA_W-1:0]    w_sq;
    logic                    w_fade_zero;
    logic [FADE_W:0]         w_rem_sh;
    logic [FADE_W:0]         w_rem_sub;
    logic [FADE_W:0]         w_rem_nxt;
    logic                    w_q_bit;
    logic                    w_div_last;
    logic                    w_mult_last;
    logic signed [THR_W-1:0] w_thr_sel;
    logic signed [CUT_W-1:0] w_cc_ext;
    logic signed [CUT_W-1:0] w_thr_ext;
    logic signed [CUT_W-1:0] w_prod;
    logic                    w_unused;

    function automatic logic signed [THR_W-1:0] thr_init(input int k);
        case (k)
            0:       return THR_W'(-85);
            1:       return THR_W'(-173);
            2:       return THR_W'(-105);
            3:       return THR_W'(-62);
            default: return THR_W'(-41);
        endcase
    endfunction

    assign w_sq        = {{SIGMA_W{1'b0}}, r_sigma} * {{SIGMA_W{1'b0}}, r_sigma};
    assign w_fade_zero = (r_fade == '0);

    // Restoring division: numerator bits leave at the top of r_num while quotient bits enter at the bottom.
    assign w_rem_sh    = {r_rem, r_num[CC_W-1]};
    assign w_rem_sub   = w_rem_sh - {1'b0, r_fade};
    assign w_q_bit     = (w_rem_sh >= {1'b0, r_fade});
    assign w_rem_nxt   = w_q_bit ? w_rem_sub : w_rem_sh;
    assign w_div_last  = (r_cnt == CNT_W'(CC_W - 1));
    assign w_mult_last = (r_idx == IDX_W'(NUM_THR - 1));

    // Operands pre-extended to the cutoff width so the product is already the truncated result.
    assign w_cc_ext  = {{THR_W{1'b0}}, o_channel_char};
    assign w_thr_ext = {{CC_W{w_thr_sel[THR_W-1]}}, w_thr_sel};
    assign w_prod    = w_cc_ext * w_thr_ext;

`ifdef THRESH_PROG_EN
    logic signed [THR_W-1:0] r_thr [NUM_THR];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_THR; k++) r_thr[k] <= thr_init(k);
        end else if (i_thr_wr_en && !o_busy) begin
            for (int k = 0; k < NUM_THR; k++) begin
                if (i_thr_wr_addr == IDX_W'(k)) r_thr[k] <= i_thr_wr_data;
            end
        end
    end

    assign w_thr_sel = r_thr[r_idx];
    assign w_unused  = w_rem_nxt[FADE_W];
`else
    always_comb begin
        w_thr_sel = thr_init(int'(r_idx));
    end

    assign w_unused = ^{w_rem_nxt[FADE_W], i_thr_wr_en, i_thr_wr_addr, i_thr_wr_data};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_SQUARE;
            S_SQUARE: w_state_nxt = w_fade_zero ? S_MULT : S_DIVIDE;
            S_DIVIDE: if (w_div_last) w_state_nxt = S_MULT;
            S_MULT:   if (w_mult_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sigma        <= '0;
            r_fade         <= '0;
            r_num          <= '0;
            r_rem          <= '0;
            r_cnt          <= '0;
            r_idx          <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_div_by_zero  <= 1'b0;
            o_sigma_square <= '0;
            o_channel_char <= '0;
            o_cutoff_valid <= 1'b0;
            o_cutoff_idx   <= '0;
            o_cutoff       <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sigma <= i_sigma_value;
                        r_fade  <= i_fade_value;
                        o_busy  <= 1'b1;
                    end
                end
                S_SQUARE: begin
                    o_sigma_square <= w_sq;
                    r_num          <= {w_sq, {SCALE_SHIFT{1'b0}}};
                    r_rem          <= '0;
                    r_cnt          <= '0;
                    r_idx          <= '0;
                    o_div_by_zero  <= w_fade_zero;
                    if (w_fade_zero) o_channel_char <= '1;
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nxt[FADE_W-1:0];
                    r_num <= {r_num[CC_W-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_div_last) o_channel_char <= {r_num[CC_W-2:0], w_q_bit};
                end
                S_MULT: begin
                    o_cutoff       <= w_prod;
                    o_cutoff_valid <= 1'b1;
                    o_cutoff_idx   <= r_idx;
                    r_idx          <= r_idx + IDX_W'(1);
                end
                S_DONE: begin
                    o_done         <= 1'b1;
                    o_busy         <= 1'b0;
                    o_cutoff_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_erasure_threshold_engine.sv
// Randomised and directed jobs checked against an arithmetic model of the cutoff stream and its timing.
module tb_erasure_threshold_engine;

    localparam int SIGMA_W     = 5;
    localparam int FADE_W      = 10;
    localparam int SCALE_SHIFT = 5;
    localparam int CC_W        = 15;
    localparam int THR_W       = 9;
    localparam int NUM_THR     = 4;
    localparam int IDX_W       = 2;
    localparam int SQ_W        = 2 * SIGMA_W;
`ifdef THRESH_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic i_start;
    logic [SIGMA_W-1:0] i_sigma_value;
    logic [FADE_W-1:0] i_fade_value;
    logic i_thr_wr_en;
    logic [IDX_W-1:0] i_thr_wr_addr;
    logic signed [THR_W-1:0] i_thr_wr_data;
    logic o_busy, o_done, o_div_by_zero, o_cutoff_valid;
    logic [SQ_W-1:0] o_sigma_square;
    logic [CC_W-1:0] o_channel_char;
    logic [IDX_W-1:0] o_cutoff_idx;
    logic signed [CC_W+THR_W-1:0] o_cutoff;

    always #5 clock = ~clock;

    erasure_threshold_engine #(
        .SIGMA_W(SIGMA_W), .FADE_W(FADE_W), .SCALE_SHIFT(SCALE_SHIFT), .CC_W(CC_W),
        .THR_W(THR_W), .NUM_THR(NUM_THR), .IDX_W(IDX_W)
    ) dut (
        .clock(clock), .reset(reset), .i_start(i_start),
        .i_sigma_value(i_sigma_value), .i_fade_value(i_fade_value),
        .i_thr_wr_en(i_thr_wr_en), .i_thr_wr_addr(i_thr_wr_addr), .i_thr_wr_data(i_thr_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero),
        .o_sigma_square(o_sigma_square), .o_channel_char(o_channel_char),
        .o_cutoff_valid(o_cutoff_valid), .o_cutoff_idx(o_cutoff_idx), .o_cutoff(o_cutoff)
    );

    int n_vec;
    int n_err;
    int mthr[NUM_THR];
    longint got_cut[16];
    int got_idx[16];
    int got_edge[16];
    int n_got;
    int done_edge;
    logic got_busy0;

    function automatic longint model_cc(input int s, input int f);
        if (f == 0) return (longint'(1) << CC_W) - 1;
        return (longint'(s) * s * (longint'(1) << SCALE_SHIFT)) / f;
    endfunction

    task automatic model_table_reset();
        mthr[0] = -85;
        mthr[1] = -173;
        mthr[2] = -105;
        mthr[3] = -62;
        for (int k = 4; k < NUM_THR; k++) mthr[k] = -41;
    endtask

    task automatic launch(input int s, input int f);
        @(negedge clock);
        i_start       = 1'b1;
        i_sigma_value = SIGMA_W'(s);
        i_fade_value  = FADE_W'(f);
    endtask

    // Next posedge is edge 0. Records the cutoff stream until done; optionally disturbs the job at
    // glitch_edge (ignored start + table write) or chains a new start into the done cycle.
    task automatic collect(input int glitch_edge, input bit chain, input int ns, input int nf);
        @(posedge clock); #1;
        got_busy0 = o_busy;
        i_start   = 1'b0;
        n_got     = 0;
        done_edge = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock); #1;
            i_start     = 1'b0;
            i_thr_wr_en = 1'b0;
            if (o_cutoff_valid && n_got < 16) begin
                got_cut[n_got]  = longint'(o_cutoff);
                got_idx[n_got]  = int'(o_cutoff_idx);
                got_edge[n_got] = e;
                n_got++;
            end
            if (o_done) begin
                done_edge = e;
                if (chain) begin
                    i_start       = 1'b1;
                    i_sigma_value = SIGMA_W'(ns);
                    i_fade_value  = FADE_W'(nf);
                end
                break;
            end
            if (e == glitch_edge) begin
                i_start       = 1'b1;
                i_sigma_value = SIGMA_W'(31);
                i_fade_value  = FADE_W'(1);
                i_thr_wr_en   = 1'b1;
                i_thr_wr_addr = '0;
                i_thr_wr_data = THR_W'(77);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if ({o_busy, o_done, o_div_by_zero, o_sigma_square, o_channel_char, o_cutoff_valid, o_cutoff_idx, o_cutoff} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b sq=%0d cc=%0d vld=%b idx=%0d cut=%0d, want all 0",
                     o_busy, o_done, o_div_by_zero, o_sigma_square, o_channel_char, o_cutoff_valid, o_cutoff_idx, o_cutoff);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if ({o_busy, o_done, o_cutoff_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: got busy/done/vld=%b%b%b want 000", o_busy, o_done, o_cutoff_valid);
        end
    endtask

    task automatic test_jobs();
        int dir_s[3]  = '{14, 31, 10};
        int dir_f[3]  = '{512, 1, 0};
        int dir_cc[3] = '{12, 30752, 32767};
        int dir_c0[3] = '{-1020, -2613920, -2785195};
        int dir_c1[3] = '{-2076, -5320096, -5668691};
        int s, f, first;
        longint cc;
        for (int j = 0; j < 23; j++) begin
            if (j < 3) begin
                s = dir_s[j];
                f = dir_f[j];
            end else begin
                s = int'($urandom_range(0, 31));
                f = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1023));
            end
            cc    = model_cc(s, f);
            first = (f == 0) ? 2 : CC_W + 2;
            launch(s, f);
            collect(-1, 1'b0, 0, 0);
            n_vec++;
            if (got_busy0 !== 1'b1) begin
                n_err++; $display("FAIL job_busy job=%0d: got %b want 1", j, got_busy0);
            end
            n_vec++;
            if (done_edge != first + NUM_THR) begin
                n_err++; $display("FAIL job_done_edge job=%0d: got %0d want %0d", j, done_edge, first + NUM_THR);
            end
            n_vec++;
            if (o_busy !== 1'b0 || o_cutoff_valid !== 1'b0) begin
                n_err++; $display("FAIL job_done_cycle job=%0d: got busy=%b vld=%b want 0 0", j, o_busy, o_cutoff_valid);
            end
            n_vec++;
            if (o_sigma_square !== SQ_W'(s * s)) begin
                n_err++; $display("FAIL job_sigma_sq job=%0d: got %0d want %0d", j, o_sigma_square, s * s);
            end
            n_vec++;
            if (o_channel_char !== CC_W'(cc)) begin
                n_err++; $display("FAIL job_cc s=%0d f=%0d: got %0d want %0d", s, f, o_channel_char, cc);
            end
            n_vec++;
            if (o_div_by_zero !== (f == 0)) begin
                n_err++; $display("FAIL job_dbz f=%0d: got %b want %b", f, o_div_by_zero, (f == 0));
            end
            n_vec++;
            if (n_got != NUM_THR) begin
                n_err++; $display("FAIL job_count job=%0d: got %0d want %0d", j, n_got, NUM_THR);
            end
            for (int k = 0; k < n_got && k < NUM_THR; k++) begin
                n_vec++;
                if (got_idx[k] != k || got_edge[k] != first + k || got_cut[k] != cc * mthr[k]) begin
                    n_err++;
                    $display("FAIL job_cutoff s=%0d f=%0d k=%0d: got idx=%0d edge=%0d val=%0d want idx=%0d edge=%0d val=%0d",
                             s, f, k, got_idx[k], got_edge[k], got_cut[k], k, first + k, cc * mthr[k]);
                end
            end
            if (j < 3) begin
                n_vec++;
                if (o_channel_char !== CC_W'(dir_cc[j]) || got_cut[0] != dir_c0[j] || got_cut[1] != dir_c1[j]) begin
                    n_err++;
                    $display("FAIL job_plan j=%0d: got cc=%0d c0=%0d c1=%0d want cc=%0d c0=%0d c1=%0d",
                             j, o_channel_char, got_cut[0], got_cut[1], dir_cc[j], dir_c0[j], dir_c1[j]);
                end
            end
        end
    endtask

    task automatic test_table_write();
        longint want1;
        @(negedge clock);
        i_thr_wr_en   = 1'b1;
        i_thr_wr_addr = IDX_W'(1);
        i_thr_wr_data = THR_W'(-50);
        @(negedge clock);
        i_thr_wr_en = 1'b0;
        if (PROG) mthr[1] = -50;
        want1 = PROG ? -600 : -2076;
        launch(14, 512);
        collect(-1, 1'b0, 0, 0);
        n_vec++;
        if (n_got != NUM_THR || got_cut[1] != want1 || got_cut[1] != 12 * mthr[1]) begin
            n_err++; $display("FAIL table_write: got n=%0d c1=%0d want n=%0d c1=%0d", n_got, got_cut[1], NUM_THR, want1);
        end
        n_vec++;
        if (got_cut[0] != 12 * mthr[0] || got_cut[2] != 12 * mthr[2]) begin
            n_err++; $display("FAIL table_other: got c0=%0d c2=%0d want %0d %0d", got_cut[0], got_cut[2], 12 * mthr[0], 12 * mthr[2]);
        end
    endtask

    task automatic test_busy_ignores();
        int extra;
        launch(14, 512);
        collect(8, 1'b0, 0, 0);
        n_vec++;
        if (o_channel_char !== CC_W'(model_cc(14, 512)) || done_edge != CC_W + 2 + NUM_THR) begin
            n_err++; $display("FAIL busy_start: got cc=%0d done=%0d want %0d %0d", o_channel_char, done_edge, model_cc(14, 512), CC_W + 2 + NUM_THR);
        end
        n_vec++;
        if (got_cut[0] != -1020 || got_cut[0] != 12 * mthr[0]) begin
            n_err++; $display("FAIL busy_write: got c0=%0d want %0d", got_cut[0], 12 * mthr[0]);
        end
        extra = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock); #1;
            if (o_busy || o_cutoff_valid || o_done) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++; $display("FAIL busy_no_queue: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        launch(14, 512);
        collect(-1, 1'b1, 31, 1);
        n_vec++;
        if (done_edge != CC_W + 2 + NUM_THR || o_channel_char !== CC_W'(model_cc(14, 512))) begin
            n_err++; $display("FAIL b2b_first: got done=%0d cc=%0d want %0d %0d", done_edge, o_channel_char, CC_W + 2 + NUM_THR, model_cc(14, 512));
        end
        collect(-1, 1'b0, 0, 0);
        n_vec++;
        if (got_busy0 !== 1'b1 || n_got < 1 || got_edge[0] != CC_W + 2) begin
            n_err++; $display("FAIL b2b_latency: got busy=%b n=%0d edge=%0d want 1 >=1 %0d", got_busy0, n_got, got_edge[0], CC_W + 2);
        end
        n_vec++;
        if (o_channel_char !== CC_W'(model_cc(31, 1)) || got_cut[0] != model_cc(31, 1) * mthr[0]) begin
            n_err++; $display("FAIL b2b_second: got cc=%0d c0=%0d want %0d %0d", o_channel_char, got_cut[0], model_cc(31, 1), model_cc(31, 1) * mthr[0]);
        end
    endtask

    task automatic test_reset_mid_job();
        int extra;
        launch(14, 512);
        @(posedge clock); #1;
        i_start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        model_table_reset();
        n_vec++;
        if ({o_busy, o_done, o_div_by_zero, o_sigma_square, o_channel_char, o_cutoff_valid, o_cutoff_idx, o_cutoff} !== '0) begin
            n_err++; $display("FAIL abort_outputs: got busy=%b sq=%0d cc=%0d cut=%0d want all 0", o_busy, o_sigma_square, o_channel_char, o_cutoff);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        extra = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock); #1;
            if (o_busy || o_cutoff_valid || o_done) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra);
        end
        launch(14, 512);
        collect(-1, 1'b0, 0, 0);
        n_vec++;
        if (n_got != NUM_THR || done_edge != CC_W + 2 + NUM_THR || o_channel_char !== CC_W'(12)) begin
            n_err++; $display("FAIL abort_rerun: got n=%0d done=%0d cc=%0d want %0d %0d 12", n_got, done_edge, o_channel_char, NUM_THR, CC_W + 2 + NUM_THR);
        end
        n_vec++;
        if (got_cut[0] != 12 * mthr[0] || got_cut[1] != -2076 || got_cut[3] != 12 * mthr[3]) begin
            n_err++; $display("FAIL abort_table: got c0=%0d c1=%0d c3=%0d want %0d -2076 %0d", got_cut[0], got_cut[1], got_cut[3], 12 * mthr[0], 12 * mthr[3]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        i_start       = 1'b0;
        i_sigma_value = '0;
        i_fade_value  = '0;
        i_thr_wr_en   = 1'b0;
        i_thr_wr_addr = '0;
        i_thr_wr_data = '0;
        model_table_reset();
        test_reset();
        test_jobs();
        test_table_write();
        test_busy_ignores();
        test_back_to_back();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
